// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin N-master / M-slave shared bus with hold limit and decode error flag
module bus_rr_arbiter #(
    parameter int NUM_M    = 4,
    parameter int NUM_S    = 8,
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int SLV_LSB  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_M-1:0]    M_req,
    input  logic [NUM_M-1:0]    M_wr,
    input  logic [NUM_M*AW-1:0] M_address,
    input  logic [NUM_M*DW-1:0] M_dout,
    output logic [NUM_M-1:0]    M_grant,
    output logic [DW-1:0]       M_din,
    output logic [NUM_S-1:0]    S_sel,
    output logic [AW-1:0]       S_address,
    output logic                S_wr,
    output logic [DW-1:0]       S_din,
    input  logic [NUM_S*DW-1:0] S_dout,
    output logic                decode_err
);
    localparam int OW = $clog2(NUM_M);
    localparam int IW = NUM_S > 1 ? $clog2(NUM_S) : 1;
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state, state_nx;
    logic [NUM_M-1:0]  grant_nx, others;
    logic [OW-1:0]     rr_ptr, rr_nx, owner, own_nx, start, pick_idx;
    logic [HW-1:0]     hold_cnt, hold_nx;
    logic [AW-1:0]     idx;
    logic [IW-1:0]     rd_idx;
    logic              pick_ok, rearb, act, in_range, rd_valid;

    // Owner index and slave-side mux of the granted master's fields (zero unless it is requesting)
    always_comb begin
        owner     = '0;
        S_address = '0;
        S_wr      = 1'b0;
        S_din     = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (M_grant[i]) begin
                owner = OW'(i);
                if (M_req[i]) begin
                    S_address = M_address[i*AW +: AW];
                    S_wr      = M_wr[i];
                    S_din     = M_dout[i*DW +: DW];
                end
            end
        end
    end

    assign act      = |(M_grant & M_req);
    assign idx      = S_address >> SLV_LSB;
    assign in_range = int'(idx) < NUM_S;
    assign S_sel    = (act && in_range) ? NUM_S'(1) << idx : '0;

    // The owner is never a candidate: released owners have no request, preempted ones must yield
    assign others = M_req & ~M_grant;
    assign own_nx = OW'((int'(owner) + 1) % NUM_M);
    assign start  = (state == IDLE) ? rr_ptr : own_nx;

    // Round-robin search: first requester at or after start, wrapping
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (others[(int'(start) + k) % NUM_M]) begin
                pick_ok  = 1'b1;
                pick_idx = OW'((int'(start) + k) % NUM_M);
            end
        end
    end

    // Next-state: re-arbitrate when idle, on release, or when the hold limit expires under contention
    always_comb begin
        state_nx = state;
        grant_nx = M_grant;
        rr_nx    = rr_ptr;
        hold_nx  = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        rearb    = (state == IDLE) || !M_req[owner] ||
                   (MAX_HOLD > 0 && hold_cnt == HOLD_LAST && |others);
        if (rearb) begin
            hold_nx  = '0;
            state_nx = pick_ok ? OWNED : IDLE;
            grant_nx = pick_ok ? NUM_M'(1) << pick_idx : '0;
            rr_nx    = pick_ok ? OW'((int'(pick_idx) + 1) % NUM_M) : rr_ptr;
        end
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            M_grant  <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            M_grant  <= grant_nx;
            rr_ptr   <= rr_nx;
            hold_cnt <= hold_nx;
        end
    end

    // Read-return pipeline stage and decode error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid   <= 1'b0;
            rd_idx     <= '0;
            decode_err <= 1'b0;
        end else begin
            rd_valid   <= act && in_range && !S_wr;
            rd_idx     <= idx[IW-1:0];
            decode_err <= act && !in_range;
        end
    end

    // Return the selected slave's data one cycle after its select, zero otherwise
    always_comb begin
        M_din = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (rd_valid && rd_idx == IW'(j)) M_din = S_dout[j*DW +: DW];
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: scoreboard bench for bus_rr_arbiter with synchronous-read slave models
module tb_bus_rr_arbiter;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   M_req, M_wr, M_grant;
    logic [31:0]  M_address;
    logic [127:0] M_dout;
    logic [31:0]  M_din, S_din;
    logic [7:0]   S_sel, S_address;
    logic         S_wr, decode_err;
    logic [255:0] S_dout;

    logic [1:0]   nh_req, nh_wr, nh_grant;
    logic [15:0]  nh_addr;
    logic [63:0]  nh_dout;
    logic [31:0]  nh_din, nh_sdin;
    logic [7:0]   nh_sel, nh_saddr;
    logic         nh_swr, nh_err;
    logic [255:0] nh_sdout;

    typedef struct {logic [31:0] din; logic err;} exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:7][0:15];
    logic [31:0] smem [0:7][0:15];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter dut (
        .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_wr(M_wr), .M_address(M_address),
        .M_dout(M_dout), .M_grant(M_grant), .M_din(M_din), .S_sel(S_sel), .S_address(S_address),
        .S_wr(S_wr), .S_din(S_din), .S_dout(S_dout), .decode_err(decode_err)
    );

    bus_rr_arbiter #(.NUM_M(2), .MAX_HOLD(0)) dut_nh (
        .clk(clk), .reset_n(reset_n), .M_req(nh_req), .M_wr(nh_wr), .M_address(nh_addr),
        .M_dout(nh_dout), .M_grant(nh_grant), .M_din(nh_din), .S_sel(nh_sel), .S_address(nh_saddr),
        .S_wr(nh_swr), .S_din(nh_sdin), .S_dout(nh_sdout), .decode_err(nh_err)
    );

    // Eight synchronous-read slaves, 16 words each
    always @(posedge clk) begin
        for (int j = 0; j < 8; j++) begin
            if (S_sel[j] && S_wr) smem[j][S_address[3:0]] <= S_din;
            S_dout[j*32 +: 32] <= smem[j][S_address[3:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("m_din", M_din, e.din);
            check("decode_err", 32'(decode_err), 32'(e.err));
        end
    endtask

    // One access by master m in a cycle where it already owns the bus
    task automatic bus_cycle(input int m, input logic [7:0] a, input logic wr, input logic [31:0] d);
        int   idx;
        exp_t e;
        @(negedge clk);
        pop_check();
        M_address[m*8 +: 8] = a;
        M_wr[m]             = wr;
        M_dout[m*32 +: 32]  = d;
        #1;
        idx = int'(a >> 4);
        check("grant_hold", 32'(M_grant), 32'(1) << m);
        check("s_sel", 32'(S_sel), idx < 8 ? 32'(1) << idx : 32'd0);
        check("s_wr", 32'(S_wr), 32'(wr));
        check("s_addr", 32'(S_address), 32'(a));
        if (wr) check("s_din", S_din, d);
        if (wr && idx < 8) ref_mem[idx][a[3:0]] = d;
        e.din = (!wr && idx < 8) ? ref_mem[idx][a[3:0]] : 32'd0;
        e.err = idx >= 8;
        exp_q.push_back(e);
    endtask

    initial begin
        int seq [5] = '{0, 1, 2, 3, 0};
        reset_n = 1'b0;
        M_req = '0; M_wr = '0; M_address = '0; M_dout = '0;
        nh_req = '0; nh_wr = '0; nh_addr = '0; nh_dout = '0; nh_sdout = '0;
        #1;
        check("rst_grant", 32'(M_grant), 0);
        check("rst_err", 32'(decode_err), 0);
        check("rst_din", M_din, 0);
        check("rst_sel", 32'(S_sel), 0);
        repeat (2) @(negedge clk);

        // Everyone requests: each owner keeps the bus for exactly 16 cycles
        reset_n = 1'b1;
        M_req   = 4'b1111;
        nh_req  = 2'b11;
        for (int w = 0; w < 5; w++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                check($sformatf("rr_w%0d_c%0d", w, c), 32'(M_grant), 32'(1) << seq[w]);
                check("nohold", 32'(nh_grant), 32'b01);
            end
        end
        M_req = '0;
        @(negedge clk);
        check("idle", 32'(M_grant), 0);

        // M2 alone: writes, pipelined reads, decode errors
        M_req = 4'b0100;
        bus_cycle(2, 8'h23, 1'b1, 32'hDEADBEEF);
        bus_cycle(2, 8'h23, 1'b0, 32'h0);
        bus_cycle(2, 8'h24, 1'b1, 32'h12345678);
        bus_cycle(2, 8'h71, 1'b1, 32'hCAFEF00D);
        bus_cycle(2, 8'h23, 1'b0, 32'h0);
        bus_cycle(2, 8'h71, 1'b0, 32'h0);
        bus_cycle(2, 8'h24, 1'b0, 32'h0);
        bus_cycle(2, 8'hA0, 1'b0, 32'h0);
        bus_cycle(2, 8'h24, 1'b0, 32'h0);
        bus_cycle(2, 8'hA0, 1'b1, 32'h55AA55AA);
        @(negedge clk);
        pop_check();
        M_req = '0;
        @(negedge clk);
        check("idle2", 32'(M_grant), 0);
        check("err_clear", 32'(decode_err), 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        // Handover without dead cycle, then re-request waits for release
        M_address = '0; M_wr = '0;
        M_req = 4'b0001;
        @(negedge clk); check("m0_own", 32'(M_grant), 32'b0001);
        M_req = 4'b1001;
        @(negedge clk); check("m0_keep", 32'(M_grant), 32'b0001);
        M_req = 4'b1000;
        @(negedge clk); check("handover", 32'(M_grant), 32'b1000);
        M_req = 4'b1001;
        @(negedge clk); check("m3_keep1", 32'(M_grant), 32'b1000);
        @(negedge clk); check("m3_keep2", 32'(M_grant), 32'b1000);
        M_req = 4'b0001;
        @(negedge clk); check("m0_back", 32'(M_grant), 32'b0001);
        M_req = '0;
        @(negedge clk); check("idle3", 32'(M_grant), 0);

        // Asynchronous reset while M1 is writing
        M_req = 4'b0010;
        M_address[15:8] = 8'h35; M_wr[1] = 1'b1; M_dout[63:32] = 32'h22222222;
        @(negedge clk);
        #1;
        check("m1_grant", 32'(M_grant), 32'b0010);
        check("m1_sel", 32'(S_sel), 32'b0000_1000);
        #2 reset_n = 1'b0;
        #1;
        check("arst_grant", 32'(M_grant), 0);
        check("arst_sel", 32'(S_sel), 0);
        check("arst_wr", 32'(S_wr), 0);
        check("arst_nh", 32'(nh_grant), 0);
        M_req = 4'b1111;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rr_restart", 32'(M_grant), 32'b0001);
        check("nh_restart", 32'(nh_grant), 32'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
